mod_blk_loader: RTL and testbench



---
 rtl/aes_pkg.sv | 16 +
 rtl/mod_blk_loader.sv | 120 ++++++++++++
 tb/tb_mod_blk_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types for the AES256 datapath: byte/block types, block size, loader states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [15:0] block_t;

   localparam int AES_NB = 16;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } ldr_state_e;

endpackage

// File: rtl/mod_blk_loader.sv
// Packs a stream of BPB-byte words into one NB-byte block and holds it for the state register.
// Latency: blk_valid rises 1 cycle after the final beat of a block is accepted.
// Backpressure: in_ready drops while a full block waits; it returns the cycle after blk_ready is taken.
//
// Ports:
//   clk       - sole clock, rising edge
//   resetn    - synchronous reset, active-high (1 = reset), overrides everything
//   clr       - synchronous flush of a partial or held block (blk_o contents kept)
//   in_valid / in_ready / in_data - upstream word handshake; byte 0 is the top byte of in_data
//   blk_o     - packed block, blk_o[k] is the k-th received byte
//   blk_valid / blk_ready - one-beat block handshake towards the state register
//   blk_cnt   - count of block handshakes, present only when MOD_BLK_LOADER_CNT_EN is defined
module mod_blk_loader
   import aes_pkg::*;
#(
   parameter int NB  = AES_NB,
   parameter int BPB = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BPB*8-1:0]    in_data,
   output logic [NB-1:0][7:0]  blk_o,
   output logic                blk_valid,
   input  logic                blk_ready
`ifdef MOD_BLK_LOADER_CNT_EN
   ,
   output logic [31:0]         blk_cnt
`endif
);

   localparam int BEATS = NB / BPB;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   ldr_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NB-1:0][7:0]      blk_q, blk_d;
   logic                    blk_valid_q, blk_valid_d;

   logic beat_acc;
   logic blk_hs;

   assign in_ready  = (state_q == FILL);
   assign blk_o     = blk_q;
   assign blk_valid = blk_valid_q;

   assign beat_acc = (state_q == FILL) && in_valid;
   assign blk_hs   = (state_q == FULL) && blk_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;

      if (clr) begin
         // Flush wins over a same-cycle beat or handshake; the beat is dropped.
         state_d = FILL;
         cnt_d   = '0;
      end else if (beat_acc) begin
         // Constant-index lane writes, selected by the current beat number.
         for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
               for (int j = 0; j < BPB; j++) begin
                  blk_d[b*BPB + j] = in_data[(BPB-j)*8-1 -: 8];
               end
            end
         end
         if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = FULL;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (blk_hs) begin
         state_d = FILL;
      end

      blk_valid_d = (state_d == FULL);
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         blk_q       <= '0;
         blk_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blk_q       <= blk_d;
         blk_valid_q <= blk_valid_d;
      end
   end

`ifdef MOD_BLK_LOADER_CNT_EN
   logic [31:0] blk_cnt_q, blk_cnt_d;

   // Counts every handshake seen on the block interface; wraps naturally.
   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (blk_valid_q && blk_ready) begin
         blk_cnt_d = blk_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         blk_cnt_q <= '0;
      end else begin
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_mod_blk_loader.sv
// Self-checking bench for mod_blk_loader: directed scenarios plus a randomized stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_mod_blk_loader;

   logic              clk;
   logic              resetn;
   logic              clr;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_data;
   logic [15:0][7:0]  blk_o;
   logic              blk_valid;
   logic              blk_ready;
`ifdef MOD_BLK_LOADER_CNT_EN
   logic [31:0]       blk_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mod_blk_loader #(.NB(16), .BPB(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .blk_o     (blk_o),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready)
`ifdef MOD_BLK_LOADER_CNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; blk_ready = 1'b0;
      tick(); tick();
      resetn = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++;
      if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_blk_valid got %b want 0", blk_valid); end
      n_checks++;
      if (blk_o !== '0) begin n_fail++; $display("FAIL reset_blk_o got %h want 0", blk_o); end
   endtask

   task automatic test_fill();
      logic [31:0] words [4];
      words[0] = 32'h00010203; words[1] = 32'h04050607;
      words[2] = 32'h08090A0B; words[3] = 32'h0C0D0E0F;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid beat %0d got %b want 0", i, blk_valid); end
         send_beat(words[i]);
      end
      n_checks++;
      if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL fill_blk_valid got %b want 1", blk_valid); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if (blk_o[k] !== 8'(k)) begin n_fail++; $display("FAIL fill_byte %0d got %h want %h", k, blk_o[k], 8'(k)); end
      end
   endtask

   task automatic test_hold();
      logic [15:0][7:0] held;
      held = blk_o;
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (blk_o !== held || blk_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable cycle %0d blk_o %h want %h valid %b ready %b", c, blk_o, held, blk_valid, in_ready);
         end
      end
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
         n_fail++; $display("FAIL hold_release ready %b valid %b want 1 0", in_ready, blk_valid);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (blk_o[0] !== 8'hDE || blk_o[1] !== 8'hAD || blk_o[2] !== 8'hBE || blk_o[3] !== 8'hEF) begin
         n_fail++; $display("FAIL hold_next_beat got %h %h %h %h want DE AD BE EF", blk_o[0], blk_o[1], blk_o[2], blk_o[3]);
      end
      n_checks++;
      if (blk_o[15:4] !== held[15:4]) begin
         n_fail++; $display("FAIL hold_stale_bytes got %h want %h", blk_o[15:4], held[15:4]);
      end
   endtask

   task automatic test_clr();
      // Flush the partial beat from the previous scenario; contents stay.
      clr = 1'b1; tick(); clr = 1'b0;
      n_checks++;
      if (blk_o[0] !== 8'hDE) begin n_fail++; $display("FAIL clr_keeps_data got %h want DE", blk_o[0]); end
      send_beat(32'hAAAAAAAA);
      send_beat(32'hBBBBBBBB);
      clr = 1'b1;
      send_beat(32'hCCCCCCCC);
      clr = 1'b0;
      send_beat(32'h11111111);
      send_beat(32'h22222222);
      send_beat(32'h33333333);
      n_checks++;
      if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL clr_early_valid got %b want 0", blk_valid); end
      send_beat(32'h44444444);
      n_checks++;
      if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL clr_blk_valid got %b want 1", blk_valid); end
      for (int k = 0; k < 16; k++) begin
         logic [7:0] e;
         e = 8'(((k / 4) + 1) * 8'h11);
         n_checks++;
         if (blk_o[k] !== e) begin n_fail++; $display("FAIL clr_byte %0d got %h want %h", k, blk_o[k], e); end
      end
      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
   endtask

   task automatic test_reset_full();
      for (int i = 0; i < 4; i++) send_beat($urandom | 32'h01010101);
      n_checks++;
      if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL rstfull_setup got %b want 1", blk_valid); end
      resetn = 1'b1; in_valid = 1'b1; blk_ready = 1'b1; clr = 1'b1;
      tick();
      resetn = 1'b0; in_valid = 1'b0; blk_ready = 1'b0; clr = 1'b0;
      n_checks++;
      if (blk_valid !== 1'b0 || in_ready !== 1'b1 || blk_o !== '0) begin
         n_fail++; $display("FAIL rstfull valid %b ready %b blk_o %h want 0 1 0", blk_valid, in_ready, blk_o);
      end
   endtask

   task automatic test_random();
      logic [7:0] sent [$];
      logic [7:0] cur  [$];
      int  blocks_done = 0;
      int  cycles      = 0;
      bit  full        = 0;
      bit  iv, br;
      logic [31:0] w;
      while (blocks_done < 100 && cycles < 20000) begin
         iv = ($urandom_range(0, 3) != 0);
         br = ($urandom_range(0, 2) == 0);
         w  = $urandom;
         in_valid = iv; in_data = w; blk_ready = br;
         #1;
         n_checks++;
         if (in_ready !== !full || blk_valid !== full) begin
            n_fail++; $display("FAIL rand_flags cycle %0d ready %b valid %b model_full %0d", cycles, in_ready, blk_valid, full);
         end
         if (full && br) begin
            for (int k = 0; k < 16; k++) begin
               logic [7:0] e;
               e = sent.pop_front();
               n_checks++;
               if (blk_o[k] !== e) begin
                  n_fail++; $display("FAIL rand_byte block %0d byte %0d got %h want %h", blocks_done, k, blk_o[k], e);
               end
            end
            blocks_done++;
         end
         // Reference: a word enters while not holding a block; 16 bytes make a block.
         if (!full && iv) begin
            for (int j = 3; j >= 0; j--) cur.push_back(w[j*8 +: 8]);
            if (cur.size() == 16) begin
               while (cur.size() > 0) sent.push_back(cur.pop_front());
               full = 1;
            end
         end else if (full && br) begin
            full = 0;
         end
         tick();
         cycles++;
      end
      in_valid = 1'b0; blk_ready = 1'b0;
      n_checks++;
      if (blocks_done != 100) begin n_fail++; $display("FAIL rand_timeout blocks %0d want 100", blocks_done); end
   endtask

`ifdef MOD_BLK_LOADER_CNT_EN
   task automatic test_cnt();
      resetn = 1'b1; tick(); resetn = 1'b0;
      n_checks++;
      if (blk_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_reset got %h want 0", blk_cnt); end
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 4; i++) send_beat($urandom);
         blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      end
      clr = 1'b1; tick(); clr = 1'b0;
      n_checks++;
      if (blk_cnt !== 32'd3) begin n_fail++; $display("FAIL cnt_three got %h want 3", blk_cnt); end
      for (int i = 0; i < 4; i++) send_beat($urandom);
      force dut.blk_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.blk_cnt_q;
      blk_ready = 1'b1; tick(); blk_ready = 1'b0;
      n_checks++;
      if (blk_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap got %h want 0", blk_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_hold();
      test_clr();
      test_reset_full();
      test_random();
`ifdef MOD_BLK_LOADER_CNT_EN
      test_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
